fifo_shift_serializer: RTL and testbench
========================================

// Module: fifo_shift_serializer
// PURPOSE
// - Buffers IN_W-bit words from the host write stream in an internal FIFO.
// - Serialises each word into IN_W/OUT_W symbols of OUT_W bits on a valid/ready output stream.
// - Sits between the host write channel and the bit-level transmit/processing datapath.
// - Successor to the fixed 32->2 shift FIFO: parametrised width/depth, backpressure, zero-bubble reload, flush.
// PARAMETERS
// - IN_W    32   input word width; must be a multiple of OUT_W, and IN_W/OUT_W >= 2
// - OUT_W   2    output symbol width
// - DEPTH   512  FIFO depth in words; power of 2, >= 2
// - AW      $clog2(DEPTH)  derived; FIFO pointer width
// PORTS
// - clk             in   1        single clock; all logic on rising edge
// - rst             in   1        synchronous reset, active-high
// - flush           in   1        synchronous clear of FIFO and shift register; contents dropped
// - data_in         in   IN_W     input word
// - data_in_valid   in   1        data_in is valid this cycle
// - data_in_ready   out  1        = !fifo_full; a word is written when data_in_valid && data_in_ready
// - data_out        out  OUT_W    current symbol
// - data_out_valid  out  1        data_out is valid
// - data_out_ready  in   1        consumer accepts; a symbol transfers when valid && ready
// - fifo_full       out  1        FIFO holds DEPTH words
// - fifo_empty      out  1        FIFO holds 0 words
// - fifo_level      out  AW+1     FIFO occupancy, 0..DEPTH
// - sr_empty        out  1        no word loaded in the shift register
// BEHAVIOUR
// - Reset (rst=1 at an edge): pointers=0, fifo_level=0, fifo_empty=1, fifo_full=0,
//   sr_empty=1, data_out_valid=0, data_out=0, symbol counter=0. flush has the same effect; rst wins.
// - FIFO: write pointer advances on each accepted write; level updates on the same edge.
//   A write when full is not accepted: data_in_ready=0, input ignored, no overflow.
//   Simultaneous pop and accepted write: level unchanged. Pointers wrap modulo DEPTH.
// - Pop rule: pop when !fifo_empty && (sr_empty || last symbol transferring this cycle).
//   On pop, head word loads into the shift register on the same edge. The FIFO read is combinational from the head.
// - Latency: word accepted at edge N -> data_out_valid=1 after edge N+1 when the FIFO was empty and sr_empty=1.
// - Output stage is registered, and data_out is the low OUT_W bits of the shift register.
//   data_out_valid = !sr_empty.
// - Hold: while data_out_valid && !data_out_ready, data_out and the counter stay unchanged.
// - Transfer: shift right by OUT_W, with zero fill; counter += 1.
//   On the transfer with counter == IN_W/OUT_W-1:
//     if FIFO non-empty, reload the next word the same edge (no bubble) and set the counter to 0;
//     otherwise set sr_empty=1 and data_out_valid=0.
// - Flush mid-word: the remaining symbols are discarded, and the next word begins at symbol 0.
// - Words are never reordered, duplicated or dropped except by rst/flush.
// CONFIGURATION
// - SHIFT_MSB_FIRST_EN defined:
//   - symbols are emitted from the most significant end first;
//   - data_out is the top OUT_W bits;
//   - the shift is left.
// - SHIFT_MSB_FIRST_EN undefined (default): LSB-first, as described above.
// - The macro affects only symbol order; latency, handshakes and flags are identical.
// TESTING (IN_W=32, OUT_W=2, DEPTH=4 unless noted)
// - Write 32'hE4E4E4E4 with ready held 1:
//   - valid rises 1 cycle after the write;
//   - symbols are 0,1,2,3 repeated 4x (16 symbols);
//   - then valid=0 and sr_empty=1.
// - Same with SHIFT_MSB_FIRST_EN defined: symbols are 3,2,1,0 repeated 4x.
// - Write 32'h00000000 then 32'hFFFFFFFF back-to-back, with ready held 1:
//   - 16x symbol 0, then immediately 16x symbol 3;
//   - data_out_valid never drops between the words.
// - With ready=0, write 5 words:
//   - the first word is loaded into the shift register, and 4 fill the FIFO;
//   - fifo_full=1 and data_in_ready=0;
//   - a 6th write is ignored;
//   - all 5 words come out in order once ready=1.
// - With ready toggling 1/0 every cycle:
//   - data_out is stable whenever ready=0;
//   - exactly 16 transfers occur per word.
// - Flush (and separately rst) after 5 symbols with 2 words queued:
//   - next cycle: valid=0, fifo_level=0, sr_empty=1;
//   - a new write of 32'h1 yields symbol 1 then 15x symbol 0.

Source files
------------

// File: rtl/fifo_shift_serializer.sv
// ---------------------------------------------------------------------------------------------
// fifo_shift_serializer
//
// Buffers IN_W-bit words from a host write stream in a DEPTH-word FIFO and serialises each word
// into IN_W/OUT_W symbols of OUT_W bits on a valid/ready output stream. When the last symbol of
// a word transfers and another word is waiting, that word loads on the same edge, so there is
// no bubble between words.
//
// Build option:
//   SHIFT_MSB_FIRST_EN  when defined, symbols leave from the most significant end of each word
//                       (data_out is the top OUT_W bits and the register shifts left). Latency,
//                       handshakes and flags are the same in both builds.
//
// Ports:
//   clk             clock, all state on the rising edge
//   rst             synchronous reset, active-high (takes priority over flush)
//   flush           synchronous clear of FIFO and shift register, contents dropped
//   data_in         input word
//   data_in_valid   data_in valid this cycle
//   data_in_ready   FIFO not full; a word is written when valid && ready
//   data_out        current symbol
//   data_out_valid  a word is loaded in the shift register
//   data_out_ready  consumer accepts; a symbol transfers when valid && ready
//   fifo_full       FIFO holds DEPTH words
//   fifo_empty      FIFO holds no words
//   fifo_level      FIFO occupancy, 0..DEPTH
//   sr_empty        no word loaded in the shift register
//
// IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2; DEPTH must be a power of 2, >= 2.
// ---------------------------------------------------------------------------------------------
module fifo_shift_serializer #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 2,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [IN_W-1:0]  data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [AW:0]      fifo_level,
  output logic             sr_empty
);

  localparam int unsigned NSYM = IN_W / OUT_W;
  localparam int unsigned CW   = $clog2(NSYM);

  localparam logic [AW-1:0] PtrOne    = AW'(1);
  localparam logic [AW:0]   LevelOne  = (AW + 1)'(1);
  localparam logic [AW:0]   LevelFull = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] CntOne    = CW'(1);
  localparam logic [CW-1:0] CntLast   = CW'(NSYM - 1);

  // ---------------------------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------------------------
  logic [IN_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [IN_W-1:0] head;

  // ---------------------------------------------------------------------------------------------
  // Shift register state
  // ---------------------------------------------------------------------------------------------
  logic [IN_W-1:0] sr_q, sr_d;
  logic [IN_W-1:0] sr_shift;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sr_empty_q, sr_empty_d;

  // Handshake decode
  logic wr_en;
  logic xfer;
  logic last_xfer;
  logic pop;

  assign fifo_full     = (level_q == LevelFull);
  assign fifo_empty    = (level_q == '0);
  assign fifo_level    = level_q;
  assign data_in_ready = !fifo_full;

  assign wr_en     = data_in_valid && data_in_ready;
  assign xfer      = !sr_empty_q && data_out_ready;
  assign last_xfer = xfer && (cnt_q == CntLast);
  // Refill whenever the register is idle or is handing off its final symbol this cycle.
  assign pop       = !fifo_empty && (sr_empty_q || last_xfer);

  assign head = mem_q[rd_ptr_q];

`ifdef SHIFT_MSB_FIRST_EN
  assign sr_shift = {sr_q[IN_W-OUT_W-1:0], {OUT_W{1'b0}}};
  assign data_out = sr_q[IN_W-1 -: OUT_W];
`else
  assign sr_shift = {{OUT_W{1'b0}}, sr_q[IN_W-1:OUT_W]};
  assign data_out = sr_q[OUT_W-1:0];
`endif

  assign data_out_valid = !sr_empty_q;
  assign sr_empty       = sr_empty_q;

  // ---------------------------------------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
  end

  // Storage is not reset; validity is tracked by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Shift register next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    sr_empty_d = sr_empty_q;
    if (pop) begin
      // Covers both the idle load and the zero-bubble reload on the last symbol.
      sr_d       = head;
      cnt_d      = '0;
      sr_empty_d = 1'b0;
    end else if (xfer) begin
      sr_d = sr_shift;
      if (last_xfer) begin
        cnt_d      = '0;
        sr_empty_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      sr_empty_q <= 1'b1;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      sr_empty_q <= sr_empty_d;
    end
  end

endmodule

// File: tb/tb_fifo_shift_serializer.sv
// ---------------------------------------------------------------------------------------------
// tb_fifo_shift_serializer
//
// Self-checking bench for fifo_shift_serializer (IN_W=32, OUT_W=2, DEPTH=4). Every cycle the
// DUT flags and output are compared with a queue-based model of the word stream; a table of
// hand-derived vectors, a few directed multi-cycle sequences and a randomised run follow.
// ---------------------------------------------------------------------------------------------
module tb_fifo_shift_serializer;

  localparam int unsigned IN_W  = 32;
  localparam int unsigned OUT_W = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned NSYM  = IN_W / OUT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic [IN_W-1:0]   data_in = '0;
  logic              data_in_valid = 1'b0;
  logic              data_in_ready;
  logic [OUT_W-1:0]  data_out;
  logic              data_out_valid;
  logic              data_out_ready = 1'b0;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW:0]       fifo_level;
  logic              sr_empty;

  fifo_shift_serializer #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_level    (fifo_level),
    .sr_empty      (sr_empty)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: queued words plus the word currently being emitted.
  logic [IN_W-1:0]  mq[$];
  logic [IN_W-1:0]  m_cur = '0;
  int               m_idx = 0;
  bit               m_loaded = 1'b0;

  // Symbols seen transferring (valid && ready at an edge).
  logic [OUT_W-1:0] got[$];

  // Symbol order of 32'hE4E4E4E4 within each byte.
  int sym[4];

  function automatic int sym_pos(int k);
`ifdef SHIFT_MSB_FIRST_EN
    return IN_W - OUT_W - OUT_W * k;
`else
    return OUT_W * k;
`endif
  endfunction

  function automatic logic [OUT_W-1:0] sym_of(logic [IN_W-1:0] w, int k);
    return OUT_W'(w >> sym_pos(k));
  endfunction

  function automatic logic [IN_W-1:0] word_of(int base);
    logic [IN_W-1:0] w = '0;
    for (int k = 0; k < NSYM; k++) begin
      w = w | (IN_W'(got[base + k]) << sym_pos(k));
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit f, input bit v, input logic [IN_W-1:0] d,
                              input bit rd);
    bit acc;
    if (r || f) begin
      mq.delete();
      m_loaded = 1'b0;
      m_idx    = 0;
      return;
    end
    acc = v && (mq.size() < DEPTH);
    if (m_loaded && rd) begin
      m_idx++;
      if (m_idx == NSYM) m_loaded = 1'b0;
    end
    if (!m_loaded && mq.size() > 0) begin
      m_cur    = mq.pop_front();
      m_idx    = 0;
      m_loaded = 1'b1;
    end
    if (acc) mq.push_back(d);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare everything just after.
  task automatic cycle(input bit r, input bit f, input bit v, input logic [IN_W-1:0] d,
                       input bit rd);
    logic [15:0] act, exp;
    logic [OUT_W-1:0] e_dout;
    rst            = r;
    flush          = f;
    data_in_valid  = v;
    data_in        = d;
    data_out_ready = rd;
    #1;
    if (!r && !f && data_out_valid === 1'b1 && rd) got.push_back(data_out);
    @(posedge clk);
    model_update(r, f, v, d, rd);
    #1;
    e_dout = m_loaded ? sym_of(m_cur, m_idx) : '0;
    act = {6'd0, data_out_valid, data_out, fifo_level, fifo_full, fifo_empty, data_in_ready,
           sr_empty};
    exp = {6'd0, m_loaded, e_dout, 3'(mq.size()), mq.size() == DEPTH, mq.size() == 0,
           mq.size() != DEPTH, !m_loaded};
    check("model", 32'(act), 32'(exp));
  endtask

  typedef struct {
    bit              r, f, v;
    logic [IN_W-1:0] d;
    bit              rd;
    bit              e_valid;
    int              e_dout;
    int              e_level;
    bit              e_full, e_empty, e_sr_empty;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [IN_W-1:0] w[6];
    int bad;
    int unstable;
    bit rd;
    bit pv;
    logic [OUT_W-1:0] pd;

`ifdef SHIFT_MSB_FIRST_EN
    sym = '{3, 2, 1, 0};
`else
    sym = '{0, 1, 2, 3};
`endif

    // ----- table-driven vectors: expected state right after each edge -----
    vecs[0] = '{1, 0, 0, 32'h0,        1, 0, 0,      0, 0, 1, 1};
    vecs[1] = '{0, 0, 1, 32'hE4E4E4E4, 1, 0, 0,      1, 0, 0, 1};
    vecs[2] = '{0, 0, 0, 32'h0,        1, 1, sym[0], 0, 0, 1, 0};
    vecs[3] = '{0, 0, 0, 32'h0,        1, 1, sym[1], 0, 0, 1, 0};
    vecs[4] = '{0, 0, 0, 32'h0,        0, 1, sym[1], 0, 0, 1, 0};
    vecs[5] = '{0, 0, 0, 32'h0,        1, 1, sym[2], 0, 0, 1, 0};
    vecs[6] = '{0, 0, 1, 32'h1,        1, 1, sym[3], 1, 0, 0, 0};
    vecs[7] = '{0, 0, 1, 32'h2,        0, 1, sym[3], 2, 0, 0, 0};
    vecs[8] = '{0, 1, 0, 32'h0,        1, 0, 0,      0, 0, 1, 1};
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].r, vecs[i].f, vecs[i].v, vecs[i].d, vecs[i].rd);
      check($sformatf("vec%0d", i),
            {data_out_valid, 2'(data_out), 3'(fifo_level), fifo_full, fifo_empty, sr_empty},
            {vecs[i].e_valid, 2'(vecs[i].e_dout), 3'(vecs[i].e_level), vecs[i].e_full,
             vecs[i].e_empty, vecs[i].e_sr_empty});
    end

    // ----- E4E4E4E4 with ready held high: 16 symbols then idle -----
    cycle(1, 0, 0, 0, 1);
    got.delete();
    cycle(0, 0, 1, 32'hE4E4E4E4, 1);
    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 0, 1);
    check("e4_count", got.size(), 16);
    bad = 0;
    for (int k = 0; k < got.size(); k++) if (int'(got[k]) != sym[k % 4]) bad++;
    check("e4_symbols", bad, 0);
    check("e4_idle", {data_out_valid, sr_empty}, 2'b01);

    // ----- zeros then ones back-to-back: no bubble between words -----
    cycle(1, 0, 0, 0, 1);
    got.delete();
    cycle(0, 0, 1, 32'h00000000, 1);
    cycle(0, 0, 1, 32'hFFFFFFFF, 1);
    for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 1);
    check("b2b_count", got.size(), 32);
    bad = 0;
    for (int k = 0; k < got.size(); k++) if (got[k] != ((k < 16) ? 2'd0 : 2'd3)) bad++;
    check("b2b_symbols", bad, 0);
    check("b2b_done", data_out_valid, 0);

    // ----- fill with ready low: 1 in shift register + 4 queued, 6th write ignored -----
    cycle(1, 0, 0, 0, 0);
    got.delete();
    w = '{32'h11112222, 32'h3333CCCC, 32'hDEADBEEF, 32'h0F0F1234, 32'h89ABCDEF, 32'h55555555};
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, w[i], 0);
    check("fill_flags", {fifo_full, data_in_ready, 3'(fifo_level), sr_empty}, {2'b10, 3'd4, 1'b0});
    cycle(0, 0, 1, w[5], 0);
    check("fill_6th_ignored", {fifo_full, 3'(fifo_level)}, {1'b1, 3'd4});
    for (int i = 0; i < 90; i++) cycle(0, 0, 0, 0, 1);
    check("fill_count", got.size(), 80);
    if (got.size() == 80) begin
      for (int i = 0; i < 5; i++) check($sformatf("fill_word%0d", i), word_of(16 * i), w[i]);
    end

    // ----- ready toggling: output holds while ready is low -----
    cycle(1, 0, 0, 0, 0);
    got.delete();
    cycle(0, 0, 1, 32'hA5C3961E, 0);
    cycle(0, 0, 1, 32'h7E81BD42, 0);
    unstable = 0;
    for (int i = 0; i < 80; i++) begin
      rd = (i % 2) == 0;
      pv = data_out_valid;
      pd = data_out;
      cycle(0, 0, 0, 0, rd);
      if (!rd && pv && data_out !== pd) unstable++;
    end
    check("toggle_stable", unstable, 0);
    check("toggle_count", got.size(), 32);
    if (got.size() == 32) begin
      check("toggle_word0", word_of(0), 32'hA5C3961E);
      check("toggle_word1", word_of(16), 32'h7E81BD42);
    end

    // ----- flush (mode 0) and reset (mode 1) mid-word with 2 words queued -----
    for (int mode = 0; mode < 2; mode++) begin
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 1, 32'hFFFFFFFF, 0);
      cycle(0, 0, 1, 32'hAAAAAAAA, 0);
      cycle(0, 0, 1, 32'h55555555, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
      check($sformatf("mid%0d_queued", mode), 3'(fifo_level), 3'd2);
      cycle(mode == 1, mode == 0, 0, 0, 1);
      check($sformatf("mid%0d_cleared", mode),
            {data_out_valid, 3'(fifo_level), sr_empty, fifo_empty}, {1'b0, 3'd0, 1'b1, 1'b1});
      got.delete();
      cycle(0, 0, 1, 32'h1, 1);
      for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 1);
      check($sformatf("mid%0d_count", mode), got.size(), 16);
      bad = 0;
      for (int k = 0; k < got.size(); k++) begin
`ifdef SHIFT_MSB_FIRST_EN
        if (got[k] != ((k == 15) ? 2'd1 : 2'd0)) bad++;
`else
        if (got[k] != ((k == 0) ? 2'd1 : 2'd0)) bad++;
`endif
      end
      check($sformatf("mid%0d_symbols", mode), bad, 0);
    end

    // ----- randomised traffic against the model, ready bias varied by phase -----
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
            $urandom, $urandom_range(0, 3) <= (i / 500) % 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
